// File: rtl/can_pkg.sv
// Shared CAN definitions: TX back-end states and CRC-15 / bit-stuffing constants.
package can_pkg;

  localparam int CAN_CRC_W = 15;
  localparam logic [CAN_CRC_W-1:0] CAN_CRC_POLY = 15'h4599;
  localparam int CAN_STUFF_LEN = 5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FRAME,
    S_CRC,
    S_CRC_DEL,
    S_ACK,
    S_ACK_DEL,
    S_EOF,
    S_IFS
  } can_tx_state_t;

endpackage

// File: rtl/can_crc15.sv
// Single-bit CAN CRC-15 step, shared by the TX and RX paths.
module can_crc15
  import can_pkg::*;
(
  input  logic [CAN_CRC_W-1:0] crc_in,
  input  logic                 bit_in,
  output logic [CAN_CRC_W-1:0] crc_out
);

  logic fb;

  assign fb = bit_in ^ crc_in[CAN_CRC_W-1];

  assign crc_out = {crc_in[CAN_CRC_W-2:0], 1'b0}
                 ^ (fb ? CAN_CRC_POLY : '0);

endmodule

// File: rtl/can_tx_stuff_crc.sv
// CAN TX back end: CRC-15 append, frame tail, bit stuffing, registered TX pin.
module can_tx_stuff_crc
  import can_pkg::*;
#(
  parameter int EOF_BITS = 7,
  parameter int IFS_BITS = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 bit_tick,
  input  logic                 in_valid,
  input  logic                 in_bit,
  input  logic                 in_last,
  output logic                 in_ready,
  output logic                 can_tx,
  output logic                 busy,
  output logic                 done,
  output logic                 underrun,
  output logic [CAN_CRC_W-1:0] frame_crc
);

  can_tx_state_t state_q, state_d;

  logic [CAN_CRC_W-1:0] crc_q, crc_d;
  logic [CAN_CRC_W-1:0] fcrc_q, fcrc_d;
  logic [CAN_CRC_W-1:0] crc_seed, crc_nx;
  logic                 tx_q, tx_d;
  logic                 done_q, done_d;
  logic                 urun_q, urun_d;
  logic                 last_q, last_d;
  logic [2:0]           run_q, run_d;
  logic                 stuff_q, stuff_d;
  logic [3:0]           cnt_q, cnt_d;

  logic [3:0] crc_idx;
  logic       crc_bit;
  logic       data_bit;
  logic [2:0] run_nx;
  logic       hit;

  assign in_ready = bit_tick && !stuff_q
                 && (state_q == S_IDLE || state_q == S_FRAME);

  assign crc_seed = (state_q == S_IDLE) ? '0 : crc_q;

  can_crc15 u_crc (
    .crc_in  (crc_seed),
    .bit_in  (in_bit),
    .crc_out (crc_nx)
  );

  assign crc_idx  = 4'(CAN_CRC_W - 1) - cnt_q;
  assign crc_bit  = fcrc_q[crc_idx];
  assign data_bit = (state_q == S_CRC) ? crc_bit : in_bit;

  // SOF always starts a fresh run regardless of what preceded it
  assign run_nx = (state_q == S_IDLE || data_bit != last_q)
                ? 3'd1 : run_q + 3'd1;
  assign hit    = (run_nx == 3'(CAN_STUFF_LEN));

  always_comb begin
    state_d = state_q;
    crc_d   = crc_q;
    fcrc_d  = fcrc_q;
    tx_d    = tx_q;
    last_d  = last_q;
    run_d   = run_q;
    stuff_d = stuff_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    urun_d  = 1'b0;
    if (bit_tick) begin
      unique case (state_q)
        S_IDLE: begin
          if (in_valid && in_ready && !in_bit) begin
            tx_d    = 1'b0;
            last_d  = 1'b0;
            run_d   = run_nx;
            stuff_d = hit;
            crc_d   = crc_nx;
            if (in_last) begin
              fcrc_d  = crc_nx;
              cnt_d   = '0;
              state_d = S_CRC;
            end else begin
              state_d = S_FRAME;
            end
          end
        end
        S_FRAME: begin
          if (stuff_q) begin
            tx_d    = ~last_q;
            last_d  = ~last_q;
            run_d   = 3'd1;
            stuff_d = 1'b0;
          end else if (!in_valid) begin
            urun_d  = 1'b1;
            tx_d    = 1'b1;
            state_d = S_IDLE;
          end else begin
            tx_d    = data_bit;
            last_d  = data_bit;
            run_d   = run_nx;
            stuff_d = hit;
            crc_d   = crc_nx;
            if (in_last) begin
              fcrc_d  = crc_nx;
              cnt_d   = '0;
              state_d = S_CRC;
            end
          end
        end
        S_CRC: begin
          if (stuff_q) begin
            tx_d    = ~last_q;
            last_d  = ~last_q;
            run_d   = 3'd1;
            stuff_d = 1'b0;
            if (cnt_q == 4'd15) begin
              cnt_d   = '0;
              state_d = S_CRC_DEL;
            end
          end else begin
            tx_d    = data_bit;
            last_d  = data_bit;
            run_d   = run_nx;
            stuff_d = hit;
            cnt_d   = cnt_q + 4'd1;
            // cnt parks at 15 when a stuff bit trails the last CRC bit
            if (cnt_q == 4'(CAN_CRC_W - 1) && !hit) begin
              cnt_d   = '0;
              state_d = S_CRC_DEL;
            end
          end
        end
        S_CRC_DEL: begin
          tx_d    = 1'b1;
          stuff_d = 1'b0;
          state_d = S_ACK;
        end
        S_ACK: begin
          tx_d    = 1'b1;
          state_d = S_ACK_DEL;
        end
        S_ACK_DEL: begin
          tx_d    = 1'b1;
          cnt_d   = '0;
          state_d = S_EOF;
        end
        S_EOF: begin
          tx_d  = 1'b1;
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'(EOF_BITS - 1)) begin
            cnt_d   = '0;
            state_d = S_IFS;
          end
        end
        S_IFS: begin
          tx_d  = 1'b1;
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'(IFS_BITS - 1)) begin
            cnt_d   = '0;
            done_d  = 1'b1;
            state_d = S_IDLE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      crc_q   <= '0;
      fcrc_q  <= '0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
      urun_q  <= 1'b0;
      last_q  <= 1'b0;
      run_q   <= '0;
      stuff_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      crc_q   <= crc_d;
      fcrc_q  <= fcrc_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
      urun_q  <= urun_d;
      last_q  <= last_d;
      run_q   <= run_d;
      stuff_q <= stuff_d;
      cnt_q   <= cnt_d;
    end
  end

  assign can_tx    = tx_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign underrun  = urun_q;
  assign frame_crc = fcrc_q;

endmodule

// File: tb/tb_can_tx_stuff_crc.sv
// Directed bench for can_tx_stuff_crc: pin streams, CRC, stuffing, underrun, reset.
module tb_can_tx_stuff_crc;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        bit_tick = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_bit = 1'b1;
  logic        in_last = 1'b0;
  logic        in_ready;
  logic        can_tx;
  logic        busy;
  logic        done;
  logic        underrun;
  logic [14:0] frame_crc;

  int chk_cnt  = 0;
  int pass_cnt = 0;
  int done_cnt = 0;
  int urun_cnt = 0;

  can_tx_stuff_crc #(.EOF_BITS(7), .IFS_BITS(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .bit_tick  (bit_tick),
    .in_valid  (in_valid),
    .in_bit    (in_bit),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .can_tx    (can_tx),
    .busy      (busy),
    .done      (done),
    .underrun  (underrun),
    .frame_crc (frame_crc)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (done)     done_cnt++;
    if (underrun) urun_cnt++;
  end

  task automatic chk(input string tag,
                     input logic [127:0] got,
                     input logic [127:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  function automatic logic [14:0] mcrc(input logic [63:0] bits,
                                       input int n);
    logic [14:0] c;
    logic        fb;
    c = '0;
    for (int i = 0; i < n; i++) begin
      fb = bits[i] ^ c[14];
      c  = {c[13:0], 1'b0} ^ (fb ? 15'h4599 : 15'h0);
    end
    return c;
  endfunction

  task automatic tick(input logic v, input logic b, input logic l,
                      output logic rdy);
    @(negedge clk);
    in_valid = v;
    in_bit   = b;
    in_last  = l;
    bit_tick = 1'b1;
    #1 rdy = in_ready;
    @(posedge clk);
    #1;
    bit_tick = 1'b0;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic run_frame(input logic [63:0] bits, input int n,
                           output logic [127:0] pin, output int len,
                           output logic ok);
    int   i;
    int   d0;
    logic v;
    logic rdy;
    i = 0; d0 = done_cnt; pin = '0; len = 0; ok = 1'b0;
    for (int t = 0; t < 300; t++) begin
      v = (i < n);
      tick(v, v ? bits[i] : 1'b1, v && (i == n - 1), rdy);
      if (v && rdy) i++;
      pin = {pin[126:0], can_tx};
      len++;
      if (done_cnt != d0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic drain(output logic ok);
    int   d0;
    logic rdy;
    d0 = done_cnt; ok = 1'b0;
    for (int t = 0; t < 100; t++) begin
      tick(1'b0, 1'b1, 1'b0, rdy);
      if (done_cnt != d0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  logic [127:0] pin;
  int           len;
  logic         ok;
  logic         rdy;
  int           d_snap;
  int           u_snap;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx", 128'(can_tx), 128'd1);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_done", 128'(done), 128'd0);
    chk("rst_urun", 128'(underrun), 128'd0);
    chk("rst_crc", 128'(frame_crc), 128'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // idle tick with no data: nothing moves
    tick(1'b0, 1'b1, 1'b0, rdy);
    chk("idle_rdy", 128'(rdy), 128'd1);
    chk("idle_tx", 128'(can_tx), 128'd1);

    // single SOF bit as last: CRC 0, three stuff bits
    run_frame(64'd0, 1, pin, len, ok);
    chk("f1_done", 128'(ok), 128'd1);
    chk("f1_len", 128'(len), 128'd32);
    chk("f1_pin", pin & {96'd0, 32'hFFFF_FFFF},
        128'(32'b0000010000010000010_1111111111111));
    chk("f1_crc", 128'(frame_crc), 128'h0000);
    chk("f1_busy", 128'(busy), 128'd0);

    // SOF then 1: CRC 0x4599, no stuffing
    run_frame(64'b10, 2, pin, len, ok);
    chk("f2_done", 128'(ok), 128'd1);
    chk("f2_len", 128'(len), 128'd30);
    chk("f2_pin", pin & {98'd0, 30'h3FFF_FFFF},
        128'(30'b01100010110011001_1111111111111));
    chk("f2_crc", 128'(frame_crc), 128'h4599);

    // five 1s after SOF force a stuff 0 and stall upstream
    tick(1'b1, 1'b0, 1'b0, rdy);
    chk("s_sof_busy", 128'(busy), 128'd1);
    chk("s_sof_tx", 128'(can_tx), 128'd0);
    for (int k = 0; k < 5; k++) begin
      tick(1'b1, 1'b1, 1'b0, rdy);
      chk("s_one_rdy", 128'(rdy), 128'd1);
      chk("s_one_tx", 128'(can_tx), 128'd1);
    end
    tick(1'b1, 1'b1, 1'b1, rdy);
    chk("s_stuff_rdy", 128'(rdy), 128'd0);
    chk("s_stuff_tx", 128'(can_tx), 128'd0);
    tick(1'b1, 1'b1, 1'b1, rdy);
    chk("s_sixth_rdy", 128'(rdy), 128'd1);
    chk("s_sixth_tx", 128'(can_tx), 128'd1);
    drain(ok);
    chk("s_done", 128'(ok), 128'd1);
    chk("s_crc", 128'(frame_crc), 128'(mcrc(64'b1111110, 7)));

    // underrun: valid dropped mid-frame
    d_snap = done_cnt;
    u_snap = urun_cnt;
    tick(1'b1, 1'b0, 1'b0, rdy);
    tick(1'b1, 1'b1, 1'b0, rdy);
    @(negedge clk);
    bit_tick = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    bit_tick = 1'b0;
    chk("u_pulse", 128'(underrun), 128'd1);
    chk("u_tx", 128'(can_tx), 128'd1);
    chk("u_busy", 128'(busy), 128'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("u_once", 128'(urun_cnt - u_snap), 128'd1);
    chk("u_nodone", 128'(done_cnt - d_snap), 128'd0);

    // recessive bit in IDLE is swallowed, then a 0 starts a frame
    tick(1'b1, 1'b1, 1'b0, rdy);
    chk("i1_rdy", 128'(rdy), 128'd1);
    chk("i1_tx", 128'(can_tx), 128'd1);
    chk("i1_busy", 128'(busy), 128'd0);
    run_frame(64'b10, 2, pin, len, ok);
    chk("i1_len", 128'(len), 128'd30);
    chk("i1_pin", pin & {98'd0, 30'h3FFF_FFFF},
        128'(30'b01100010110011001_1111111111111));

    // reset in the CRC field, then a clean frame
    d_snap = done_cnt;
    tick(1'b1, 1'b0, 1'b0, rdy);
    tick(1'b1, 1'b1, 1'b1, rdy);
    for (int k = 0; k < 3; k++) tick(1'b0, 1'b1, 1'b0, rdy);
    chk("r_busy_pre", 128'(busy), 128'd1);
    @(negedge clk);
    rst = 1'b1;
    bit_tick = 1'b1;
    @(posedge clk);
    #1;
    chk("r_tx", 128'(can_tx), 128'd1);
    chk("r_crc", 128'(frame_crc), 128'd0);
    chk("r_busy", 128'(busy), 128'd0);
    @(negedge clk);
    rst = 1'b0;
    bit_tick = 1'b0;
    repeat (2) @(posedge clk);
    chk("r_nodone", 128'(done_cnt - d_snap), 128'd0);
    run_frame(64'd0, 1, pin, len, ok);
    chk("r_f_done", 128'(ok), 128'd1);
    chk("r_f_len", 128'(len), 128'd32);
    chk("r_f_pin", pin & {96'd0, 32'hFFFF_FFFF},
        128'(32'b0000010000010000010_1111111111111));

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/can_tx_stuff_crc.md
# can_tx_stuff_crc

Serial back end of the CAN transmit path, directly downstream of the frame serializer. Consumes the unstuffed frame bit stream (SOF through last data bit) one bit per CAN bit time. Computes CRC-15 over it, appends CRC, CRC delimiter, ACK slot, ACK delimiter, EOF and intermission, and applies bit stuffing. Drives the registered TX pin.

## Interface
- `EOF_BITS`, default 7: number of recessive end-of-frame bits.
- `IFS_BITS`, default 3: number of recessive intermission bits before `done`.
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `bit_tick` in 1: one-cycle strobe, one per CAN bit time; the only cycle in which `can_tx` advances.
- `in_valid` in 1: upstream bit valid.
- `in_bit` in 1: upstream bit; 0 is dominant.
- `in_last` in 1: qualifies `in_bit` as the last data bit of the frame.
- `in_ready` out 1: bit consumed when `in_valid && in_ready`.
- `can_tx` out 1: TX pin, registered; idle and reset value 1.
- `busy` out 1: high in any state other than IDLE; reset 0.
- `done` out 1: one-cycle pulse after the last intermission bit; reset 0.
- `underrun` out 1: one-cycle pulse on frame abort; reset 0.
- `frame_crc` out 15: CRC of the last frame, held until the next SOF; reset 0.

## Operation
- States: IDLE, FRAME, CRC, CRC_DEL, ACK, ACK_DEL, EOF, IFS.
- `in_ready` is combinational: `bit_tick && (state==IDLE || state==FRAME) && !stuff_pending`.
- IDLE:
  - An accepted `in_bit=0` is SOF. It is sent, `crc` is initialised to 0, the SOF is fed into the CRC, and the state goes to FRAME.
  - An accepted `in_bit=1` is discarded: `can_tx` stays 1 and the state stays IDLE.
- FRAME:
  - Each accepted bit is sent and fed into the CRC.
  - An accepted bit with `in_last=1` goes to CRC. `frame_crc` captures the final CRC value, including that last bit.
- CRC step: `fb = bit ^ crc[14]`; `crc = {crc[13:0],1'b0} ^ (fb ? 15'h4599 : 0)`.
- CRC state: sends `frame_crc` MSB first, 15 bits, counted by a 4-bit counter.
- Then CRC_DEL 1, ACK 1 (transmitter sends recessive), ACK_DEL 1, EOF `EOF_BITS`×1, IFS `IFS_BITS`×1.
- After the last IFS bit the state returns to IDLE and `done` pulses.
- Stuffing, active from SOF through the last CRC bit:
  - Track the last sent bit and a 3-bit run count.
  - After 5 consecutive equal bits, `stuff_pending` is set. The next tick sends the complement, which is not fed into the CRC.
  - The stuff bit counts as run length 1 of the new value.
  - A stuff bit may follow the last CRC bit, before CRC_DEL.
- Stuffing is disabled from CRC_DEL onward, and `stuff_pending` is cleared on entering CRC_DEL.
- Underrun:
  - Condition: in FRAME, `bit_tick && !stuff_pending && !in_valid`.
  - Response: `underrun` pulses, the state goes to IDLE, and `can_tx` is set to 1.
  - No `done` and no CRC update.
- `rst` in any state: state IDLE, `can_tx`=1, `busy`/`done`/`underrun`=0, `crc`, `frame_crc` and all counters 0.

## Timing
- The `can_tx` value selected in a `bit_tick` cycle appears on the following edge and holds until the next tick.
- `busy` rises on the same edge as the SOF `can_tx` change. It falls on the edge on which `done` rises.
- A bit accepted in cycle N appears on `can_tx` at edge N+1. There is no other latency.
- While `stuff_pending` is set, `in_ready` is low in that tick, and upstream holds `in_bit`/`in_last`.
- `bit_tick` with `rst` high: `rst` wins.
- `bit_tick` with no activity in IDLE: no change.
- Frame length in bits:
  - Unstuffed: L + 15 + 3 + `EOF_BITS` + `IFS_BITS`, where L counts the bits accepted from SOF to `in_last` inclusive.
  - On the pin: that total plus the number of stuff bits.

## Structure
- Shared package `can_pkg` holds:
  - the state enum `can_tx_state_t`;
  - `CAN_CRC_W`=15;
  - `CAN_CRC_POLY`=15'h4599;
  - `CAN_STUFF_LEN`=5.
- Sub-module `can_crc15`: combinational single-bit CRC step, with inputs `crc_in` and `bit_in` and output `crc_out`. It is reused later by the RX path.
- The FSM, stuff logic and counters live in the top module.

## Test plan
- Input 0 with `in_last=1`: `frame_crc`=0x0000. Pin bits, comma-separated: 0,0,0,0,0,1,0,0,0,0,0,1,0,0,0,0,0,1,0, then 1×(3+7+3), then `done`.
- Input 0, then 1 with `in_last=1`: `frame_crc`=0x4599. Pin bits: 0,1,1,0,0,0,1,0,1,1,0,0,1,1,0,0,1, then 13×1. No stuff bits.
- Input 0,1,1,1,1,1,1: after the fifth 1, a stuff 0 is sent. `in_ready` is low on that tick, and the sixth 1 follows on the next tick.
- `in_valid` dropped in FRAME on a tick: `underrun` pulses once, `can_tx`=1, `busy`=0, no `done`.
- IDLE, accepted `in_bit=1`: `can_tx` stays 1 and `busy` stays 0. A following 0 starts the frame.
- `rst` asserted mid-CRC state: next edge `can_tx`=1 and `frame_crc`=0. A fresh frame then completes correctly.
